// File: rtl/parity_frame_tx.sv
// -----------------------------------------------------------------------------
// parity_frame_tx
//
// Upstream stage of the even-parity link. Accepts an MSG_W-bit message over a
// valid/ready handshake, computes its even-parity bit and shifts the frame out
// serially: parity first, then data LSB to MSB. A receiver that XORs all frame
// bits (p, d0, d1, ...) sees 0 for an error-free frame.
//
// Handshake: a message transfers on any rising clk edge where msg_valid and
// msg_ready are both high. msg_ready is high only in IDLE. msg_valid and
// msg_data are ignored while a frame is in flight.
//
// Optional build macro PARITY_FRAME_START_BIT_EN: when defined, a start bit of
// 1 precedes the parity bit (frame = start, parity, data[0..MSG_W-1]).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   msg_valid  in   message on msg_data is valid
//   msg_data   in   MSG_W-bit message; bit 0 is sent first after parity
//   msg_ready  out  block can accept a message this cycle
//   tx_bit     out  serial frame bit
//   tx_active  out  tx_bit carries a valid frame bit
//   frame_done out  one-cycle pulse in the first IDLE cycle after a frame
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module parity_frame_tx #(
    parameter int MSG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             msg_valid,
    input  logic [MSG_W-1:0] msg_data,
    output logic             msg_ready,
    output logic             tx_bit,
    output logic             tx_active,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(MSG_W + 2);

    // Index k of the final frame cycle; SEND lasts LAST+1 cycles.
`ifdef PARITY_FRAME_START_BIT_EN
    localparam int LAST = MSG_W + 1;
`else
    localparam int LAST = MSG_W;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    logic [MSG_W-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
`ifdef PARITY_FRAME_START_BIT_EN
    // Parity must be held for one cycle while the start bit is on the line.
    logic               parity_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            msg_ready  <= 1'b1;
            tx_bit     <= 1'b0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
`ifdef PARITY_FRAME_START_BIT_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // frame_done was raised on the last SEND edge; it lasts
                    // exactly this one IDLE cycle.
                    frame_done <= 1'b0;
                    msg_ready  <= 1'b1;
                    tx_active  <= 1'b0;
                    tx_bit     <= 1'b0;
                    if (msg_valid) begin
                        shreg     <= msg_data;
                        cnt       <= '0;
                        state     <= SEND;
                        msg_ready <= 1'b0;
                        tx_active <= 1'b1;
`ifdef PARITY_FRAME_START_BIT_EN
                        parity_q  <= ^msg_data;
                        tx_bit    <= 1'b1;
`else
                        tx_bit    <= ^msg_data;
`endif
                    end
                end

                SEND: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state      <= IDLE;
                        msg_ready  <= 1'b1;
                        tx_active  <= 1'b0;
                        tx_bit     <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        frame_done <= 1'b0;
`ifdef PARITY_FRAME_START_BIT_EN
                        if (cnt == '0) begin
                            tx_bit <= parity_q;
                        end else begin
                            tx_bit <= shreg[0];
                            shreg  <= shreg >> 1;
                        end
`else
                        // Next cycle carries data[cnt]; the register shifts
                        // internally so bit 0 is always the next data bit.
                        tx_bit <= shreg[0];
                        shreg  <= shreg >> 1;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

    localparam int MSG_W = 3;
`ifdef PARITY_FRAME_START_BIT_EN
    localparam bit START = 1'b1;
`else
    localparam bit START = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             msg_valid = 1'b0;
    logic [MSG_W-1:0] msg_data = '0;
    logic             msg_ready;
    logic             tx_bit;
    logic             tx_active;
    logic             frame_done;

    always #5 clk = ~clk;

    parity_frame_tx #(.MSG_W(MSG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .msg_valid  (msg_valid),
        .msg_data   (msg_data),
        .msg_ready  (msg_ready),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .frame_done (frame_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Present a message just after a falling edge and return one cycle later,
    // i.e. inside the first frame cycle. msg_valid is left high.
    task automatic drive_msg(input logic [MSG_W-1:0] d);
        msg_valid = 1'b1;
        msg_data  = d;
        @(negedge clk);
    endtask

    // Called inside the first frame cycle. exp[0] is the parity bit, exp[k]
    // is data[k-1]. Checks every frame cycle, the frame_done cycle, then
    // advances to the cycle after frame_done. mid_data is applied during the
    // frame to show it is ignored.
    task automatic check_frame(input string tag, input logic [3:0] exp,
                               input logic [MSG_W-1:0] mid_data);
        logic x;
        x = 1'b0;
        if (START) begin
            chk({tag, "_start_bit"}, tx_bit, 1'b1);
            chk({tag, "_start_act"}, tx_active, 1'b1);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 1) msg_data = mid_data;
            chk($sformatf("%s_bit%0d", tag, k), tx_bit, exp[k]);
            chk($sformatf("%s_act%0d", tag, k), tx_active, 1'b1);
            chk($sformatf("%s_rdy%0d", tag, k), msg_ready, 1'b0);
            chk($sformatf("%s_done%0d", tag, k), frame_done, 1'b0);
            x = x ^ tx_bit;
            @(negedge clk);
        end
        chk({tag, "_detector_xor"}, x, 1'b0);
        chk({tag, "_done_pulse"}, frame_done, 1'b1);
        chk({tag, "_done_rdy"}, msg_ready, 1'b1);
        chk({tag, "_done_act"}, tx_active, 1'b0);
        @(negedge clk);
    endtask

    // Idle cycle after frame_done with no new message.
    task automatic check_idle(input string tag);
        chk({tag, "_idle_done"}, frame_done, 1'b0);
        chk({tag, "_idle_rdy"}, msg_ready, 1'b1);
        chk({tag, "_idle_act"}, tx_active, 1'b0);
        chk({tag, "_idle_bit"}, tx_bit, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Asynchronous reset between edges, checked without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", msg_ready, 1'b1);
        chk("rst_active", tx_active, 1'b0);
        chk("rst_bit", tx_bit, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        // 000: parity 0, frame 0,0,0,0
        drive_msg(3'b000);
        msg_valid = 1'b0;
        check_frame("f000", 4'b0000, 3'b111);
        check_idle("f000");

        // 101: parity 0, frame 0,1,0,1
        drive_msg(3'b101);
        msg_valid = 1'b0;
        check_frame("f101", 4'b1010, 3'b000);
        check_idle("f101");

        // 111: parity 1, frame 1,1,1,1
        drive_msg(3'b111);
        msg_valid = 1'b0;
        check_frame("f111", 4'b1111, 3'b000);
        check_idle("f111");

        // 010: parity 1, frame 1,0,1,0 (with start bit: 1,1,0,1,0)
        drive_msg(3'b010);
        msg_valid = 1'b0;
        check_frame("f010", 4'b0101, 3'b101);
        check_idle("f010");

        // Back-to-back: 001 held, switched to 110 mid-frame.
        // First frame 1,1,0,0; second 0,0,1,1 right after frame_done.
        drive_msg(3'b001);
        check_frame("b2b_a", 4'b0011, 3'b110);
        // msg_valid stayed high, so the frame_done edge accepted 110.
        check_frame("b2b_b", 4'b1100, 3'b110);
        // valid still high: a third 110 frame is in flight; drop valid and
        // let it finish.
        msg_valid = 1'b0;
        check_frame("b2b_c", 4'b1100, 3'b000);
        check_idle("b2b");

        // Abort: reset during the 3rd bit of an 011 frame.
        drive_msg(3'b011);
        msg_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_act", tx_active, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_act", tx_active, 1'b0);
        chk("abort_rdy", msg_ready, 1'b1);
        chk("abort_bit", tx_bit, 1'b0);
        chk("abort_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_abort");
        @(negedge clk);
        check_idle("post_abort2");

        // 100: parity 1, frame 1,0,0,1 transmitted cleanly.
        drive_msg(3'b100);
        msg_valid = 1'b0;
        check_frame("f100", 4'b1001, 3'b011);
        check_idle("f100");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
- Upstream stage of the even-parity detector.
- Accepts an MSG_W-bit message over a valid/ready handshake and computes its even-parity bit.
- Shifts the frame out serially as parity first, then data LSB to MSB.
- The downstream deserializer and detector present the frame as (p, a, b, c) and see XOR = 0 for an error-free frame.

Parameters:
- MSG_W, 3, message width in bits; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- msg_valid  input  1  message on msg_data is valid
- msg_data  input  MSG_W  message; bit 0 is transmitted first after parity
- msg_ready  output  1  block can accept a message this cycle
- tx_bit  output  1  serial frame bit
- tx_active  output  1  tx_bit carries a valid frame bit
- frame_done  output  1  one-cycle pulse after the last frame bit

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, msg_ready=1, tx_bit=0, tx_active=0, frame_done=0, bit counter=0, shift register=0.
  - Assertion mid-frame aborts the frame immediately; no partial frame resumes after release.
- States: IDLE, SEND.
- IDLE:
  - msg_ready=1, tx_active=0, tx_bit=0.
  - On a clk edge with msg_valid=1, the block captures msg_data into the shift register, latches parity = XOR of all msg_data bits (even parity), clears the counter, and moves to SEND.
- SEND:
  - msg_ready=0, tx_active=1.
  - Cycle k=0 drives tx_bit=parity; cycles k=1..MSG_W drive tx_bit=captured data[k-1].
  - Frame length is MSG_W+1 cycles; the counter increments every cycle.
  - After the cycle with k=MSG_W, the block returns to IDLE.
- frame_done:
  - Registered pulse, high for exactly the first IDLE cycle after SEND.
  - That cycle also has msg_ready=1, so a message accepted then starts SEND on the next cycle.
  - Minimum frame period is MSG_W+2 cycles.
- Latency: the accept edge is followed by the parity bit on tx_bit in the next cycle.
- Inputs during SEND: msg_valid and msg_data are ignored; the captured message is never modified mid-frame.
- msg_valid held high continuously: frames are sent back-to-back at the minimum period, each capturing msg_data sampled at its own accept edge.
- Counter width is $clog2(MSG_W+2); no wrap occurs within a frame.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: PARITY_FRAME_START_BIT_EN.
- Defined:
  - A start bit of 1 precedes the parity bit, so the frame is start, parity, data[0..MSG_W-1], MSG_W+2 SEND cycles.
  - tx_active is high for all of them, including the start bit.
  - frame_done timing shifts by one cycle; the minimum period is MSG_W+3.
- Undefined: behaviour exactly as above, with no start bit and no extra logic.

Test Plan (MSG_W=3, macro undefined unless stated):
- Reset: rst_n=0 asynchronously between edges -> msg_ready=1, tx_active=0, tx_bit=0, frame_done=0 immediately, without a clock edge.
- msg_data=3'b000, msg_valid for 1 cycle -> tx_bit sequence 0,0,0,0 with tx_active=1 for 4 cycles; frame_done=1 in cycle 5; msg_ready=0 during cycles 1-4.
- msg_data=3'b101 -> tx_bit 0,1,0,1; msg_data=3'b111 -> tx_bit 1,1,1,1; detector fed (p,d0,d1,d2) outputs 0 for both.
- msg_valid held high with msg_data=3'b001 then switched to 3'b110 mid-frame -> first frame 1,1,0,0 unchanged; second frame 0,0,1,1 starts the cycle after the frame_done cycle (period 5).
- rst_n pulsed low during the 3rd bit of a 3'b011 frame -> tx_active drops immediately; after release, a new 3'b100 frame transmits 1,0,0,1 cleanly.
- PARITY_FRAME_START_BIT_EN defined, msg_data=3'b010 -> tx_bit 1,1,0,1,0 over 5 active cycles; frame_done in cycle 6.
